keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20, stable-time in clk cycles for press and release acceptance (range 2..1023).
REQ-002 SHALL have parameter SCAN_DIV, default 1, clk cycles each row is driven before its columns are sampled (range 1..15).
REQ-003 clk  input  1  system clock, 1000 Hz after reduction.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 col  input  4  matrix column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 row  output  4  matrix row drive, active-low, one-hot-low while scanning.
REQ-007 pressed  output  1  one-cycle pulse, digit key accepted.
REQ-008 key_value  output  4  binary digit 0-9 of last accepted digit key.
REQ-009 start  output  1  one-cycle pulse, start key accepted.
REQ-010 cancel  output  1  one-cycle pulse, cancel key accepted (see Configuration).

Function
REQ-011 SHALL pass col through a 2-flop synchroniser; all decisions use the synchronised value (colS).
REQ-012 Key map, row r / col c: r0-2 x c0-2 = digits 1-9 (value 3r+c+1); r3c1 = digit 0; r3c2 = start; r3c0 = cancel; c3 (all rows) ignored.
REQ-013 States: SCAN, PRESS_DB, HOLD, RELEASE_DB.
REQ-014 SCAN: drive row index i low, others high; after SCAN_DIV cycles sample colS; none low -> i = i+1 mod 4; any low -> latch i and colS, enter PRESS_DB, keep row i driven.
REQ-015 PRESS_DB: count cycles; colS differs from latched code -> return to SCAN at row i+1 mod 4, no output.
REQ-016 PRESS_DB: colS equal to latched code for DEBOUNCE_MS consecutive cycles -> decode, emit at most one pulse, enter HOLD.
REQ-017 Exactly one column low and key mapped -> pulse pressed / start / cancel for exactly one cycle; more than one column low or c3 -> no pulse (ghost / unused key).
REQ-018 key_value SHALL update in the same cycle pressed is asserted and hold until the next accepted digit; start/cancel do not change it.
REQ-019 HOLD: keep row i driven; colS all high -> RELEASE_DB; no repeated pulses while held.
REQ-020 RELEASE_DB: colS all high for DEBOUNCE_MS consecutive cycles -> SCAN at row 0; any low -> back to HOLD, counter cleared.
REQ-021 Simultaneous keys on different rows: only the first row found in scan order is processed; others are ignored until full release.
REQ-022 Outputs pressed, start, cancel SHALL never be high in the same cycle.
REQ-023 All outputs registered; pressed latency from first stable colS low = DEBOUNCE_MS cycles (+ scan/sync delay).

Reset
REQ-024 During/after reset: state SCAN, row index 0, row = 4'b1110, pressed = 0, start = 0, cancel = 0, key_value = 0, counters and synchroniser = 0 / all-high respectively.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort with no pulse; after release, a still-held key is re-detected and re-debounced from SCAN.

Configuration
REQ-026 Macro KEYPAD_CANCEL_KEY_EN: defined -> r3c0 produces cancel pulse per REQ-017.
REQ-027 Macro KEYPAD_CANCEL_KEY_EN undefined -> r3c0 treated as unused (no pulse), cancel tied to 0.

Verification
REQ-028 DEBOUNCE_MS=20, SCAN_DIV=1: hold r1c2 low 50 cycles -> exactly one pressed pulse, key_value = 6, 20 cycles after PRESS_DB entry; no further pulse until release + 20 cycles high.
REQ-029 Press r3c1 with 5-cycle bounce (low/high toggles) then stable 30 cycles -> single pressed, key_value = 0; bounce alone (<20 stable) -> no pulse.
REQ-030 Press r0c0 and r0c1 together -> no pulse; release both, press r3c2 -> single start pulse, key_value unchanged.
REQ-031 With KEYPAD_CANCEL_KEY_EN defined, press r3c0 -> one cancel pulse; undefined -> cancel stays 0, nothing emitted.
REQ-032 Assert rst_n at cycle 10 of PRESS_DB on r2c2 with key held -> no pulse, row = 4'b1110; after deassert, key re-debounced -> pressed, key_value = 9.
REQ-033 Keys r0c0 and r2c1 pressed together, r0 found first -> only key_value = 1 emitted; no second pulse until all keys released.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and digit/start/cancel decode.
// Build macro KEYPAD_CANCEL_KEY_EN enables the cancel key at row 3 / column 0.
module keypad_scanner #(
  parameter int DEBOUNCE_MS = 20,
  parameter int SCAN_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic [3:0] key_value,
  output logic       start,
  output logic       cancel,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HOLD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Row dwell adds the two synchroniser stages so colS reflects the driven row.
  localparam logic [4:0] DWELL_LAST = 5'(SCAN_DIV + 1);
  localparam logic [9:0] DB_LAST    = 10'(DEBOUNCE_MS - 1);

  state_t     state, state_d;
  logic [1:0] row_idx, row_idx_d;
  logic [4:0] div_cnt, div_cnt_d;
  logic [9:0] db_cnt, db_cnt_d;
  logic [3:0] col_lat, col_lat_d;
  logic [3:0] col_s1, col_s;
  logic [3:0] row_d, key_value_d;
  logic       pressed_d, start_d, cancel_d;

  logic [3:0] col_hit;
  logic       one_hot;
  logic [1:0] c_idx;
  logic [3:0] digit;

  assign dbg_state = state;

  // Decode works on the latched code, which equals colS whenever it is used.
  always_comb begin
    col_hit = ~col_lat;
    one_hot = (col_hit != 4'd0) && ((col_hit & (col_hit - 4'd1)) == 4'd0);
    c_idx   = col_hit[2] ? 2'd2 : (col_hit[1] ? 2'd1 : 2'd0);
    digit   = {2'b00, row_idx} + {2'b00, row_idx} + {2'b00, row_idx}
              + {2'b00, c_idx} + 4'd1;
  end

  always_comb begin
    state_d     = state;
    row_idx_d   = row_idx;
    div_cnt_d   = div_cnt;
    db_cnt_d    = db_cnt;
    col_lat_d   = col_lat;
    pressed_d   = 1'b0;
    start_d     = 1'b0;
    cancel_d    = 1'b0;
    key_value_d = key_value;
    case (state)
      SCAN: begin
        if (div_cnt == DWELL_LAST) begin
          div_cnt_d = 5'd0;
          if (col_s != 4'hF) begin
            state_d   = PRESS_DB;
            col_lat_d = col_s;
            db_cnt_d  = 10'd0;
          end else begin
            row_idx_d = row_idx + 2'd1;
          end
        end else begin
          div_cnt_d = div_cnt + 5'd1;
        end
      end
      PRESS_DB: begin
        if (col_s != col_lat) begin
          state_d   = SCAN;
          row_idx_d = row_idx + 2'd1;
          div_cnt_d = 5'd0;
          db_cnt_d  = 10'd0;
        end else if (db_cnt == DB_LAST) begin
          state_d  = HOLD;
          db_cnt_d = 10'd0;
          // Ghost (several columns) and column 3 fall through with no pulse.
          if (one_hot && !col_hit[3]) begin
            if (row_idx != 2'd3) begin
              pressed_d   = 1'b1;
              key_value_d = digit;
            end else if (c_idx == 2'd1) begin
              pressed_d   = 1'b1;
              key_value_d = 4'd0;
            end else if (c_idx == 2'd2) begin
              start_d = 1'b1;
            end else begin
`ifdef KEYPAD_CANCEL_KEY_EN
              cancel_d = 1'b1;
`else
              cancel_d = 1'b0;
`endif
            end
          end
        end else begin
          db_cnt_d = db_cnt + 10'd1;
        end
      end
      HOLD: begin
        if (col_s == 4'hF) begin
          state_d  = RELEASE_DB;
          db_cnt_d = 10'd0;
        end
      end
      RELEASE_DB: begin
        if (col_s != 4'hF) begin
          state_d  = HOLD;
          db_cnt_d = 10'd0;
        end else if (db_cnt == DB_LAST) begin
          state_d   = SCAN;
          row_idx_d = 2'd0;
          div_cnt_d = 5'd0;
          db_cnt_d  = 10'd0;
        end else begin
          db_cnt_d = db_cnt + 10'd1;
        end
      end
      default: state_d = SCAN;
    endcase
    row_d = ~(4'b0001 << row_idx_d);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      div_cnt   <= 5'd0;
      db_cnt    <= 10'd0;
      col_lat   <= 4'hF;
      col_s1    <= 4'hF;
      col_s     <= 4'hF;
      row       <= 4'b1110;
      pressed   <= 1'b0;
      start     <= 1'b0;
      cancel    <= 1'b0;
      key_value <= 4'd0;
    end else begin
      state     <= state_d;
      row_idx   <= row_idx_d;
      div_cnt   <= div_cnt_d;
      db_cnt    <= db_cnt_d;
      col_lat   <= col_lat_d;
      col_s1    <= col;
      col_s     <= col_s1;
      row       <= row_d;
      pressed   <= pressed_d;
      start     <= start_d;
      cancel    <= cancel_d;
      key_value <= key_value_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, a vector table, random presses
// checked against key-map rules, and hand-written debounce/reset sequences.
module tb_keypad_scanner;

  localparam int DB = 20;
  localparam int SD = 1;
`ifdef KEYPAD_CANCEL_KEY_EN
  localparam int CANCEL_EN = 1;
`else
  localparam int CANCEL_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic       pressed, start, cancel;
  logic [3:0] key_value;
  logic [1:0] dbg_state;

  logic [3:0] keys [4];

  int checks = 0;
  int errors = 0;
  int n_pressed = 0, n_start = 0, n_cancel = 0, n_overlap = 0, n_glitch = 0;
  logic [3:0] prev_kv = 4'd0;
  int model_kv = 0;

  typedef struct {
    int r1; int c1; int r2; int c2; int hold;
    int e_pr; int e_st; int e_ca; int e_kv;
  } vec_t;
  vec_t vecs [12];

  keypad_scanner #(.DEBOUNCE_MS(DB), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row), .pressed(pressed),
    .key_value(key_value), .start(start), .cancel(cancel), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r]) col = col & ~keys[r];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      if (pressed) n_pressed++;
      if (start)   n_start++;
      if (cancel)  n_cancel++;
      if (int'(pressed) + int'(start) + int'(cancel) > 1) n_overlap++;
      if (key_value != prev_kv && !pressed) n_glitch++;
    end
    prev_kv = key_value;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask

  // Waits for row 0 to become driven so a press is seen in row 0 first.
  task automatic wait_row0(input string name);
    bit ok = 0;
    logic [3:0] prev = row;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (row == 4'b1110 && prev != 4'b1110) begin ok = 1; break; end
      prev = row;
    end
    if (!ok) check({name, "_row0_timeout"}, 0, 1);
  endtask

  task automatic wait_state(input string name, input logic [1:0] s);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg_state == s) begin ok = 1; break; end
    end
    if (!ok) check({name, "_state_timeout"}, 0, 1);
  endtask

  task automatic apply(input string name, input int r1, input int c1, input int r2,
                       input int c2, input int hold, input int e_pr, input int e_st,
                       input int e_ca, input int e_kv);
    int p0 = n_pressed, s0 = n_start, k0 = n_cancel, o0 = n_overlap, g0 = n_glitch;
    wait_row0(name);
    keys[r1][c1] = 1'b1;
    if (r2 >= 0) keys[r2][c2] = 1'b1;
    repeat (hold) @(negedge clk);
    release_all();
    repeat (45) @(negedge clk);
    check({name, "_pressed"}, n_pressed - p0, e_pr);
    check({name, "_start"},   n_start - s0,   e_st);
    check({name, "_cancel"},  n_cancel - k0,  e_ca);
    check({name, "_key_value"}, int'(key_value), e_kv);
    check({name, "_overlap"}, n_overlap - o0, 0);
    check({name, "_kv_glitch"}, n_glitch - g0, 0);
  endtask

  // Key map from the rules: kind 0 none, 1 digit, 2 start, 3 cancel.
  function automatic void ref_key(input int r, input int c, output int kind, output int val);
    kind = 0; val = 0;
    if (c == 3) return;
    if (r < 3) begin kind = 1; val = 3 * r + c + 1; end
    else if (c == 1) begin kind = 1; val = 0; end
    else if (c == 2) kind = 2;
    else kind = CANCEL_EN ? 3 : 0;
  endfunction

  initial begin
    int p0, lat, kind, val, hold, r, c;
    bit got;
    vecs[0]  = '{1, 2, -1, 0, 50, 1, 0, 0, 6};
    vecs[1]  = '{0, 0, -1, 0, 50, 1, 0, 0, 1};
    vecs[2]  = '{2, 2, -1, 0, 50, 1, 0, 0, 9};
    vecs[3]  = '{3, 2, -1, 0, 50, 0, 1, 0, 9};
    vecs[4]  = '{3, 1, -1, 0, 50, 1, 0, 0, 0};
    vecs[5]  = '{0, 3, -1, 0, 50, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, -1, 0, 10, 0, 0, 0, 0};
    vecs[7]  = '{0, 0,  0, 1, 50, 0, 0, 0, 0};
    vecs[8]  = '{3, 2, -1, 0, 50, 0, 1, 0, 0};
    vecs[9]  = '{0, 0,  2, 1, 60, 1, 0, 0, 1};
    vecs[10] = '{3, 0, -1, 0, 50, 0, 0, CANCEL_EN, 1};
    vecs[11] = '{2, 0, -1, 0, 50, 1, 0, 0, 7};

    release_all();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_row", int'(row), 4'b1110);
    check("reset_pressed", int'(pressed), 0);
    check("reset_start", int'(start), 0);
    check("reset_cancel", int'(cancel), 0);
    check("reset_key_value", int'(key_value), 0);
    check("reset_state", int'(dbg_state), 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Debounce latency from PRESS_DB entry, no repeat while held or on re-press.
    p0 = n_pressed;
    wait_row0("lat");
    keys[1] = 4'b0100;
    wait_state("lat", 2'd1);
    lat = 0; got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (pressed) begin got = 1; break; end
    end
    check("lat_cycles", got ? lat : -1, DB);
    check("lat_key_value", int'(key_value), 6);
    repeat (25) @(negedge clk);
    check("lat_hold_single", n_pressed - p0, 1);
    release_all();
    repeat (10) @(negedge clk);
    keys[1] = 4'b0100;
    repeat (30) @(negedge clk);
    release_all();
    repeat (45) @(negedge clk);
    check("lat_repress_single", n_pressed - p0, 1);
    model_kv = 6;

    // Bounce then stable on digit 0; bounce alone gives nothing.
    p0 = n_pressed;
    for (int i = 0; i < 10; i++) begin
      keys[3] = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    keys[3] = 4'b0010;
    repeat (40) @(negedge clk);
    release_all();
    repeat (45) @(negedge clk);
    check("bounce_pressed", n_pressed - p0, 1);
    check("bounce_key_value", int'(key_value), 0);
    p0 = n_pressed;
    for (int i = 0; i < 10; i++) begin
      keys[3] = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    release_all();
    repeat (45) @(negedge clk);
    check("bounce_only_pressed", n_pressed - p0, 0);

    for (int i = 0; i < 12; i++)
      apply($sformatf("vec%0d", i), vecs[i].r1, vecs[i].c1, vecs[i].r2, vecs[i].c2,
            vecs[i].hold, vecs[i].e_pr, vecs[i].e_st, vecs[i].e_ca, vecs[i].e_kv);
    model_kv = 7;

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      hold = ($urandom_range(0, 1) == 1) ? $urandom_range(40, 70) : $urandom_range(3, 15);
      ref_key(r, c, kind, val);
      if (hold < DB) kind = 0;
      if (kind == 1) model_kv = val;
      apply($sformatf("rnd%0d_r%0dc%0d", i, r, c), r, c, -1, 0, hold,
            (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0, (kind == 3) ? 1 : 0, model_kv);
    end

    // Reset mid-debounce aborts; the held key is then re-detected.
    p0 = n_pressed;
    wait_row0("rst");
    keys[2] = 4'b0100;
    wait_state("rst", 2'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_row", int'(row), 4'b1110);
    check("rst_state", int'(dbg_state), 0);
    check("rst_key_value", int'(key_value), 0);
    check("rst_no_pulse", n_pressed - p0, 0);
    rst_n = 1'b0;
    repeat (70) @(negedge clk);
    check("rst_redebounce_pressed", n_pressed - p0, 1);
    check("rst_redebounce_key_value", int'(key_value), 9);
    release_all();
    repeat (45) @(negedge clk);
    check("final_overlap", n_overlap, 0);
    check("final_kv_glitch", n_glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
